// File: rtl/rv32_ctrl_pkg.sv
// Shared RV32 control definitions: opcode constants, immediate-format
// encodings (also consumed by the extend unit) and the decode/issue entry type.
package rv32_ctrl_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Immediate-format selects for the extend unit
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // One buffered instruction with its decode results
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm_src;
        logic        illegal;
    } issue_entry_t;

    // All-zero entry used for reset
    localparam issue_entry_t ENTRY_ZERO = '{instr: 32'd0, pc: 32'd0, imm_src: 3'b000, illegal: 1'b0};

endpackage

// File: rtl/imm_src_decode.sv
// Combinational opcode decode: immediate format select and illegal flag.
module imm_src_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] imm_src_o,
    output logic       illegal_o
);

    // Map the major opcode onto an immediate format; unknown opcodes are flagged
    always_comb begin
        imm_src_o = IMM_I;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_LOAD, OP_IMM, OP_JALR: imm_src_o = IMM_I;
            OP_STORE:                 imm_src_o = IMM_S;
            OP_BRANCH:                imm_src_o = IMM_B;
            OP_JAL:                   imm_src_o = IMM_J;
            OP_LUI, OP_AUIPC:         imm_src_o = IMM_U;
            OP_OP:                    imm_src_o = IMM_I;
            default: begin
                imm_src_o = IMM_I;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue buffer: 2-entry flop FIFO between fetch and execute.
// Decode is done at push time so the head entry is presented straight from flops.
module decode_issue_ctrl
    import rv32_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] ex_instr,
    output logic [31:0] ex_pc,
    output logic [2:0]  ex_imm_src,
    output logic        ex_illegal
);

    issue_entry_t mem_q [2];
    issue_entry_t mem_d [2];
    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         if_ready_q, if_ready_d;

    logic [2:0]   dec_imm_src_s;
    logic         dec_illegal_s;
    logic         push_s;
    logic         pop_s;

    imm_src_decode u_dec (
        .opcode_i  (if_instr[6:0]),
        .imm_src_o (dec_imm_src_s),
        .illegal_o (dec_illegal_s)
    );

    // Handshake qualification; a flush cycle never stores the offered instruction
    always_comb begin
        push_s = if_valid && if_ready_q && !flush;
        pop_s  = (count_q != 2'd0) && ex_ready;
    end

    // Next-state for pointers, occupancy, storage and the registered ready
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = '{instr: if_instr, pc: if_pc,
                                    imm_src: dec_imm_src_s, illegal: dec_illegal_s};
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        if_ready_d = (count_d != 2'd2);
    end

    // State registers; reset empties the buffer immediately and holds if_ready low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0]   <= ENTRY_ZERO;
            mem_q[1]   <= ENTRY_ZERO;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            if_ready_q <= 1'b0;
        end else begin
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if_ready_q <= if_ready_d;
        end
    end

    // Head entry is driven directly from storage flops
    always_comb begin
        if_ready   = if_ready_q;
        ex_valid   = (count_q != 2'd0);
        ex_instr   = mem_q[rd_ptr_q].instr;
        ex_pc      = mem_q[rd_ptr_q].pc;
        ex_imm_src = mem_q[rd_ptr_q].imm_src;
        ex_illegal = mem_q[rd_ptr_q].illegal;
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl with a queue-based scoreboard.
module tb_decode_issue_ctrl;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  imm;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic [2:0]  ex_imm_src;
    logic        ex_illegal;

    exp_t q[$];
    logic model_rdy;
    int   n_checks = 0;
    int   n_errors = 0;

    decode_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .ex_valid   (ex_valid),
        .ex_instr   (ex_instr),
        .ex_pc      (ex_pc),
        .ex_imm_src (ex_imm_src),
        .ex_illegal (ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive, check at negedge, update model, advance to next posedge+1
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [2:0] imm, input logic ill, input logic rdy, input logic fl);
        exp_t e;
        logic mvalid;
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
        ex_ready = rdy;
        flush    = fl;
        @(negedge clk);
        mvalid = (q.size() != 0);
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, mvalid});
        chk("if_ready", {31'd0, if_ready}, {31'd0, model_rdy});
        if (mvalid) begin
            e = q[0];
            chk("ex_instr",   ex_instr, e.instr);
            chk("ex_pc",      ex_pc, e.pc);
            chk("ex_imm_src", {29'd0, ex_imm_src}, {29'd0, e.imm});
            chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, e.ill});
        end
        if (fl) begin
            q.delete();
        end else begin
            if (mvalid && rdy) void'(q.pop_front());
            if (v && model_rdy) begin
                e.instr = instr; e.pc = pc; e.imm = imm; e.ill = ill;
                q.push_back(e);
            end
        end
        model_rdy = (q.size() != 2);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'd0, 32'd0, 3'b000, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        flush = 1'b0; ex_ready = 1'b0; model_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ex_valid",   {31'd0, ex_valid}, 32'd0);
        chk("rst if_ready",   {31'd0, if_ready}, 32'd0);
        chk("rst ex_instr",   ex_instr, 32'd0);
        chk("rst ex_pc",      ex_pc, 32'd0);
        chk("rst ex_imm_src", {29'd0, ex_imm_src}, 32'd0);
        chk("rst ex_illegal", {31'd0, ex_illegal}, 32'd0);
        reset = 1'b0;
        idle(1'b1);                                   // if_ready still 0 before first edge

        // addi, 1-cycle latency then empty
        step(1'b1, 32'h00500093, 32'h00000100, 3'b000, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // sw then beq with execute stalled; fill, hold, then drain in order
        step(1'b1, 32'h00112023, 32'h00000104, 3'b001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFE000EE3, 32'h00000108, 3'b010, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b1, 32'h00000013, 32'h0000010C, 3'b000, 1'b0, 1'b0, 1'b0); // refused: full
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // count=1, simultaneous pop of lw and push of jal
        step(1'b1, 32'h00002103, 32'h00000200, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0080006F, 32'h00000204, 3'b011, 1'b0, 1'b1, 1'b0);
        idle(1'b0);

        // fill with auipc, then flush while lui is offered
        step(1'b1, 32'h00000097, 32'h00000208, 3'b100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h123450B7, 32'h0000020C, 3'b100, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // unsupported opcode flows through
        step(1'b1, 32'hFFFFFFFF, 32'h00000300, 3'b000, 1'b1, 1'b1, 1'b0);
        idle(1'b1);

        // back-to-back stream at full rate
        step(1'b1, 32'h002081B3, 32'h00000400, 3'b000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h000080E7, 32'h00000404, 3'b000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h123450B7, 32'h00000408, 3'b100, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h00112023, 32'h0000040C, 3'b001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0000007F, 32'h00000410, 3'b000, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // fill to 2, then asynchronous reset between edges
        step(1'b1, 32'h00500093, 32'h00000500, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00112023, 32'h00000504, 3'b001, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("async if_ready", {31'd0, if_ready}, 32'd0);
        chk("async ex_instr", ex_instr, 32'd0);
        q.delete();
        model_rdy = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("post-rst if_ready", {31'd0, if_ready}, 32'd0);
        @(posedge clk);
        #1;
        model_rdy = 1'b1;
        idle(1'b1);
        step(1'b1, 32'h00000097, 32'h00000600, 3'b100, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_valid  input  1  fetch stage offers an instruction.
REQ-005 if_instr  input  32  fetched instruction word.
REQ-006 if_pc  input  32  PC of the fetched instruction.
REQ-007 if_ready  output  1  block accepts an instruction this cycle.
REQ-008 flush  input  1  discard all buffered instructions (branch/jump redirect).
REQ-009 ex_ready  output-side  input  1  execute stage accepts the head entry.
REQ-010 ex_valid  output  1  head entry is valid.
REQ-011 ex_instr  output  32  head instruction word.
REQ-012 ex_pc  output  32  head PC.
REQ-013 ex_imm_src  output  3  immediate-format select for the extend unit: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-014 ex_illegal  output  1  head instruction has an unsupported opcode.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {instr, pc, imm_src, illegal}; imm_src and illegal SHALL be decoded at push time.
REQ-016 Decode SHALL map opcode[6:0] as follows: 0000011, 0010011, 1100111 -> 000; 0100011 -> 001; 1100011 -> 010; 1101111 -> 011; 0110111, 0010111 -> 100; 0110011 -> 000 with illegal=0.
REQ-017 Any other opcode SHALL store imm_src=000 and illegal=1; an illegal entry SHALL flow through the FIFO like any other entry.
REQ-018 if_ready SHALL be the registered value of (count != 2); push SHALL occur when if_valid && if_ready.
REQ-019 ex_valid SHALL equal (count != 0); pop SHALL occur when ex_valid && ex_ready.
REQ-020 Latency from push to ex_valid SHALL be exactly 1 cycle when the FIFO is empty; there SHALL be no combinational path from if_* to ex_*.
REQ-021 ex_* SHALL hold stable while ex_valid && !ex_ready.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; at count=1 the pushed entry SHALL become the head on the next cycle.
REQ-023 Read and write pointers SHALL be 1 bit each and SHALL wrap modulo 2.
REQ-024 flush SHALL take priority over push and pop: next cycle count=0, both pointers=0, any same-cycle push is dropped, and if_ready=1.
REQ-025 Sustained throughput SHALL be 1 instruction/cycle while ex_ready=1.

Reset
REQ-026 While reset is asserted: count=0, pointers=0, ex_valid=0, if_ready=0, ex_instr=0, ex_pc=0, ex_imm_src=000, ex_illegal=0.
REQ-027 if_ready SHALL rise on the first clock edge after reset deasserts.
REQ-028 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-029 Opcode constants and the IMM_I/S/B/J/U 3-bit encodings SHALL reside in a shared package, rv32_ctrl_pkg, and SHALL also be used by the extend unit.
REQ-030 Opcode decode SHALL be one combinational sub-module, imm_src_decode (opcode in; imm_src and illegal out).
REQ-031 Storage SHALL be flops; no memory macro.

Verification
REQ-032 Reset then push 0x00500093 (addi) with ex_ready=1 -> next cycle ex_valid=1, ex_imm_src=000, ex_illegal=0, then empty.
REQ-033 ex_ready=0, push 0x00112023 (sw) then 0xFE000EE3 (beq) -> if_ready=0 after the 2nd push; raising ex_ready pops imm_src 001 then 010 in order.
REQ-034 count=1 with simultaneous push of 0x0080006F (jal) and pop -> count stays 1; next head imm_src=011.
REQ-035 count=2 with flush, if_valid=1 and 0x123450B7 (lui) offered -> next cycle ex_valid=0, if_ready=1, lui not stored.
REQ-036 Push 0xFFFFFFFF -> ex_illegal=1, ex_imm_src=000, entry pops normally.
REQ-037 Assert reset asynchronously with count=2 -> ex_valid=0 and if_ready=0 immediately, before the next clock edge.
